// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//
// Drives an N-digit common-anode 7-segment display by lighting one digit at
// a time. A shadow register holds the value on display. Each digit gets a
// slot of PRESCALE clock cycles. The first BLANK_CYC cycles of every slot
// keep all anodes off, so that segment data from the previous digit does
// not ghost onto the next one.
//
// A digit stays dark for its whole slot in either of two cases:
//   - its enable bit is clear, or
//   - it is a suppressed leading zero.
// Digit 0 is never treated as a leading zero.
//
// All outputs are registered and lag the internal scan state by one cycle.
//
// Ports:
//   clk_i     in   1         system clock
//   rst_i     in   1         synchronous reset, active-high
//   data_i    in   4*DIGITS  value to display; nibble i feeds digit i (0 = rightmost)
//   load_i    in   1         capture data_i into the shadow register
//   dig_en_i  in   DIGITS    per-digit enable, 1 = digit may light
//   lz_en_i   in   1         leading-zero suppression enable
//   hex_o     out  4         nibble of the current digit, to the 7-seg decoder
//   an_o      out  DIGITS    active-low anodes (one low bit, or all ones)
//   blank_o   out  1         1 = force all segments off this cycle
//   idx_o     out  3         current digit index
// ---------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int DIGITS    = 8,
    parameter int PRESCALE  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic                  load_i,
    input  logic [DIGITS-1:0]     dig_en_i,
    input  logic                  lz_en_i,
    output logic [3:0]            hex_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  blank_o,
    output logic [2:0]            idx_o
);

    localparam int              PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   BLANK_LEN  = PW'(BLANK_CYC);
    localparam logic [2:0]      IDX_LAST   = 3'(DIGITS - 1);

    // Scan state
    logic [PW-1:0]          r_presc;
    logic [2:0]             r_idx;
    logic [4*DIGITS-1:0]    r_shadow;

    // Per-digit views of the shadow register
    logic [3:0]             w_nib [DIGITS];
    logic [DIGITS-1:0]      w_vis;

    // Selected-digit values feeding the output registers
    logic                   w_tick;
    logic [3:0]             w_hex_cur;
    logic                   w_vis_cur;
    logic                   w_lit;
    logic [DIGITS-1:0]      w_an_lit;

    assign w_tick = (r_presc == PRESC_LAST);

    // Visibility of each digit. A digit above 0 is a leading zero when it
    // and every digit to its left hold zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign w_nib[gi] = r_shadow[4*gi +: 4];
            if (gi == 0) begin : g_first
                assign w_vis[gi] = dig_en_i[gi];
            end else begin : g_upper
                assign w_vis[gi] = dig_en_i[gi] &
                                   ~(lz_en_i & (r_shadow[4*DIGITS-1:4*gi] == '0));
            end
        end
    endgenerate

    // Select the nibble and visibility bit of the active digit. A compare
    // loop is used because DIGITS need not be a power of two.
    always_comb begin
        w_hex_cur = '0;
        w_vis_cur = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
                w_hex_cur = w_nib[i];
                w_vis_cur = w_vis[i];
            end
        end
    end

    assign w_an_lit = ~(DIGITS'(1) << r_idx);
    assign w_lit    = (r_presc >= BLANK_LEN) && w_vis_cur;

    // Prescaler and digit counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Shadow register. A load is independent of the tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow <= '0;
        end else if (load_i) begin
            r_shadow <= data_i;
        end
    end

    // Output registers. hex_o follows the active digit even while it is
    // blanked, so the decoder input is already settled when the anode
    // switches on.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hex_o   <= '0;
            an_o    <= '1;
            blank_o <= 1'b1;
            idx_o   <= '0;
        end else begin
            hex_o <= w_hex_cur;
            idx_o <= r_idx;
            if (w_lit) begin
                an_o    <= w_an_lit;
                blank_o <= 1'b0;
            end else begin
                an_o    <= '1;
                blank_o <= 1'b1;
            end
        end
    end

endmodule
